ffpack_shift_bank: RTL

FFPACK_SHIFT_BANK -- requirements
Module: ffpack_shift_bank

---
 rtl/ffpack_shift_bank_if.sv | 28 ++
 rtl/ffpack_shift_bank.sv | 66 ++++++
 2 files changed

// File: rtl/ffpack_shift_bank_if.sv
// rtl/ffpack_shift_bank_if.sv - control, data and status bundle for the shift-register bank
interface ffpack_shift_bank_if #(
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 5
);
    localparam int FW = $clog2(DEPTH + 1);

    logic                      cen;
    logic [CHANNELS-1:0]       chen;
    logic                      ld;
    logic                      dir;
    logic [CHANNELS-1:0]       sin;
    logic [CHANNELS*DEPTH-1:0] pin;
    logic [CHANNELS*DEPTH-1:0] vec;
    logic [CHANNELS-1:0]       sout;
    logic [FW-1:0]             fill;
    logic                      full;

    modport master (
        output cen, chen, ld, dir, sin, pin,
        input  vec, sout, fill, full
    );

    modport slave (
        input  cen, chen, ld, dir, sin, pin,
        output vec, sout, fill, full
    );
endinterface

// File: rtl/ffpack_shift_bank.sv
// rtl/ffpack_shift_bank.sv - bank of parallel-load bidirectional shift registers with saturating fill count
module ffpack_shift_bank #(
    parameter int                 CHANNELS  = 2,
    parameter int                 DEPTH     = 5,
    parameter logic [DEPTH-1:0]   RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    ffpack_shift_bank_if.slave bus
);
    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    logic [CHANNELS*DEPTH-1:0] vec_q = {CHANNELS{RESET_VAL}};
    logic [CHANNELS*DEPTH-1:0] vec_d;
    logic [FW-1:0]             fill_q = '0;
    logic [FW-1:0]             fill_d;
    logic                      full_q = 1'b0;
    logic                      full_d;

    always_comb begin
        vec_d  = vec_q;
        fill_d = fill_q;
        if (bus.cen) begin
            if (bus.ld) begin
                vec_d  = bus.pin;
                fill_d = FILL_MAX;
            end else begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (bus.chen[c]) begin
                        if (bus.dir)
                            vec_d[c*DEPTH +: DEPTH] = {bus.sin[c], vec_q[c*DEPTH+1 +: DEPTH-1]};
                        else
                            vec_d[c*DEPTH +: DEPTH] = {vec_q[c*DEPTH +: DEPTH-1], bus.sin[c]};
                    end
                end
                if (|bus.chen && fill_q != FILL_MAX)
                    fill_d = fill_q + FW'(1);
            end
        end
        // full is registered alongside fill so it never sees a path from the inputs
        full_d = (fill_d == FILL_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q  <= {CHANNELS{RESET_VAL}};
            fill_q <= '0;
            full_q <= 1'b0;
        end else begin
            vec_q  <= vec_d;
            fill_q <= fill_d;
            full_q <= full_d;
        end
    end

    always_comb begin
        bus.sout = '0;
        for (int c = 0; c < CHANNELS; c++)
            bus.sout[c] = bus.dir ? vec_q[c*DEPTH] : vec_q[c*DEPTH + DEPTH - 1];
    end

    assign bus.vec  = vec_q;
    assign bus.fill = fill_q;
    assign bus.full = full_q;
endmodule
